// File: rtl/uart_rx_framed.sv
// uart_rx_framed: oversampling UART receiver with stop/parity checking and a one-deep holding register.
// Parity support (PARITY state, parity_err) is built only when UART_RX_PARITY_EN is defined.
module uart_rx_framed #(
  parameter int CLK_SPEED = 5_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int BAUD_TICK = CLK_SPEED / BAUD_RATE;
  localparam int HALF_TICK = BAUD_TICK / 2;
  localparam int TW = $clog2(BAUD_TICK + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_TICK - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(HALF_TICK - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               r_state;
  logic                 r_sync1, r_sync2, r_rx_prev;
  logic [TW-1:0]        r_tick;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_ferr, r_done, r_busy;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_valid, r_ferr_out, r_overrun;
  logic                 w_rx_s, w_sample;

`ifdef UART_RX_PARITY_EN
  logic r_par_en, r_par_odd, r_perr, r_perr_out;
`else
  logic w_unused_parity;
  assign w_unused_parity = parity_en | parity_odd;
`endif

  assign w_rx_s   = r_sync2;
  assign w_sample = (r_tick == TICK_LAST);

  // r_rx_prev only sees a 1->0 step after the line has genuinely returned high,
  // which is what keeps a held break from re-triggering frames.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ferr  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_rx_prev && !w_rx_s) begin
            r_state <= START;
            r_tick  <= '0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (r_tick == TICK_HALF) begin
            r_tick <= '0;
            if (!w_rx_s) begin
              r_state <= DATA;
              r_bit   <= '0;
              r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              r_par_en  <= parity_en;
              r_par_odd <= parity_odd;
              r_perr    <= 1'b0;
`endif
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        DATA: begin
          if (w_sample) begin
            r_tick  <= '0;
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit == DATA_LAST) begin
              r_bit <= '0;
`ifdef UART_RX_PARITY_EN
              r_state <= r_par_en ? PARITY : STOP;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_sample) begin
            r_tick  <= '0;
            r_perr  <= ((^r_shift) ^ w_rx_s) != r_par_odd;
            r_state <= STOP;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_sample) begin
            r_tick <= '0;
            if (!w_rx_s) r_ferr <= 1'b1;
            if (r_bit == STOP_LAST) begin
              r_bit   <= '0;
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // A completing frame wins over a same-cycle accept; it is dropped only while the holder is still full.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_ferr_out <= 1'b0;
      r_overrun  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr_out <= 1'b0;
`endif
    end else if (r_done && (!r_valid || data_ready)) begin
      r_data_out <= r_shift;
      r_ferr_out <= r_ferr;
      r_valid    <= 1'b1;
      if (r_valid) r_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr_out <= r_perr;
`endif
    end else if (r_done) begin
      r_overrun <= 1'b1;
    end else if (r_valid && data_ready) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign data_out    = r_data_out;
  assign data_valid  = r_valid;
  assign framing_err = r_ferr_out;
  assign overrun     = r_overrun;
  assign busy        = r_busy;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_perr_out;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: doc/uart_rx_framed.md
UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 SHALL have parameter CLK_SPEED, default 5_000_000: input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600: line bit rate; BAUD_TICK = CLK_SPEED/BAUD_RATE (integer), HALF_TICK = BAUD_TICK/2.
REQ-003 SHALL have parameter DATA_BITS, default 8: legal 5..9.
REQ-004 SHALL have parameter STOP_BITS, default 1: legal 1 or 2.
REQ-005 SHALL have port clock  input  1  rising-edge clock.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port parity_en  input  1  parity bit present after the data bits; sampled at start-bit qualification.
REQ-009 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even; sampled with parity_en.
REQ-010 SHALL have port data_ready  input  1  consumer accepts the held frame.
REQ-011 SHALL have port data_out  output  DATA_BITS  received word, LSB first on the line.
REQ-012 SHALL have port data_valid  output  1  held frame available; stays high until data_ready.
REQ-013 SHALL have port framing_err  output  1  held frame had a 0 in a stop-bit slot.
REQ-014 SHALL have port parity_err  output  1  held frame failed the parity check.
REQ-015 SHALL have port overrun  output  1  sticky; a completed frame was dropped.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL pass rx through a 2-flop synchroniser; all decisions use the synchronised value rx_s.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP, with one tick counter running 0..BAUD_TICK-1 and one bit counter.
REQ-019 IDLE->START SHALL occur only on a falling edge of rx_s (previous 1, current 0); the tick counter clears on entry.
REQ-020 In START, at tick HALF_TICK-1, rx_s=0 SHALL go to DATA; rx_s=1 SHALL be treated as a glitch and return to IDLE with no output change.
REQ-021 Each subsequent bit SHALL be sampled exactly BAUD_TICK cycles after the previous sample; data bits shift in LSB first.
REQ-022 After DATA_BITS samples the FSM SHALL go to PARITY if parity_en was latched high, otherwise to STOP.
REQ-023 Parity check: even mode requires an even count of ones over data bits plus parity bit, odd mode an odd count; a mismatch sets the frame's parity flag.
REQ-024 STOP SHALL sample STOP_BITS slots; any 0 sets the frame's framing flag; after the last slot the FSM returns to IDLE.
REQ-025 A line still low after a framing error SHALL NOT start a new frame until rx_s has returned high and then fallen again (break immunity).
REQ-026 The cycle after the last stop sample, if data_valid=0, data_out/framing_err/parity_err SHALL load and data_valid SHALL go 1.
REQ-027 If data_valid=1 at that point, the new frame SHALL be discarded, held outputs SHALL remain unchanged, and overrun SHALL set.
REQ-028 data_valid && data_ready SHALL clear data_valid and overrun on the next edge; a frame completing in the same cycle SHALL be loaded, and its load takes priority.
REQ-029 data_ready while data_valid=0 SHALL have no effect.

Reset
REQ-030 reset_n low SHALL immediately force IDLE, all counters 0, synchroniser flops 1, data_out 0, and data_valid/framing_err/parity_err/overrun/busy 0.
REQ-031 Reset mid-frame SHALL abandon the frame with no output, and the next complete frame SHALL receive correctly.

Configuration
REQ-032 With macro UART_RX_PARITY_EN defined, PARITY state and parity_err logic SHALL be present per REQ-022/023.
REQ-033 Without UART_RX_PARITY_EN, ports SHALL be unchanged, parity_en/parity_odd SHALL be ignored, the PARITY state SHALL be never entered, and parity_err SHALL be tied 0.

Verification (CLK_SPEED=160000, BAUD_RATE=10000, BAUD_TICK=16, DATA_BITS=8, STOP_BITS=1, UART_RX_PARITY_EN defined)
REQ-034 Frame 0x55 8N1 with data_ready held 1 -> data_out=0x55, data_valid high 1 cycle, all error flags 0.
REQ-035 rx low for 4 cycles then high -> START aborts to IDLE, no data_valid, busy low within 10 cycles.
REQ-036 0xA3 with stop bit 0, then line held low for 40 bit times -> one data_valid with data_out=0xA3, framing_err=1, and no further frames.
REQ-037 parity_en=1, parity_odd=0, data 0x07, parity bit 0 -> parity_err=1; the same frame with parity bit 1 -> parity_err=0.
REQ-038 Frames 0x12 then 0x34 with data_ready=0 -> data_out stays 0x12 and overrun=1; a data_ready pulse then clears data_valid and overrun.
REQ-039 reset_n pulsed low during data bit 3 -> all outputs 0 immediately; the next frame 0xC6 is received with no errors.
